// File: rtl/result_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : result_bus_arbiter
//  Purpose  : Round-robin sharing of the ROB result-write ports between the
//             functional units. Up to NUM_PORTS finished FUs are granted per
//             cycle and their results are registered onto the ROB ports.
//  Revision : 1.0  initial release
// ============================================================================
module result_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_PORTS  = 2,
  parameter int IDX_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*IDX_WIDTH-1:0]    req_rob_idx,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]            res_valid,
  output logic [NUM_PORTS*IDX_WIDTH-1:0]  res_rob_idx,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] res_data,
  output logic [$clog2(NUM_REQ)-1:0]      rr_ptr_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                r_rr_ptr;
  logic [NUM_PORTS-1:0]            r_res_valid;
  logic [NUM_PORTS*IDX_WIDTH-1:0]  r_res_idx;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_res_data;

  logic [IDX_WIDTH-1:0]  w_req_idx  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
  logic [NUM_REQ-1:0]    w_grant;
  logic [NUM_PORTS-1:0]  w_port_vld;
  logic [PTR_W-1:0]      w_port_sel [NUM_PORTS];
  logic [PTR_W-1:0]      w_last;
  logic                  w_any;
  logic                  w_arb_en;

  // Requester index 'off' positions after 'base', wrapping at NUM_REQ
  // (works for non-power-of-two requester counts).
  function automatic logic [PTR_W-1:0] f_rot(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  genvar gk;
  for (gk = 0; gk < NUM_REQ; gk++) begin : g_unpack
    assign w_req_idx[gk]  = req_rob_idx[gk*IDX_WIDTH +: IDX_WIDTH];
    assign w_req_data[gk] = req_data[gk*DATA_WIDTH +: DATA_WIDTH];
  end

  // Nothing is granted while in reset or while the pipeline flushes.
  assign w_arb_en = !rst && !flush_en;

  // Circular scan from rr_ptr: each port takes the next valid, not-yet-taken
  // requester, so ports fill contiguously from 0 and never share a requester.
  always_comb begin
    logic [NUM_REQ-1:0] v_taken;
    logic               v_found;
    logic [PTR_W-1:0]   v_k;
    v_taken    = '0;
    v_found    = 1'b0;
    v_k        = '0;
    w_port_vld = '0;
    w_last     = r_rr_ptr;
    w_any      = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) w_port_sel[p] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      v_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        v_k = f_rot(r_rr_ptr, i);
        if (w_arb_en && !v_found && req_valid[v_k] && !v_taken[v_k]) begin
          v_found       = 1'b1;
          v_taken[v_k]  = 1'b1;
          w_port_vld[p] = 1'b1;
          w_port_sel[p] = v_k;
          w_last        = v_k;
          w_any         = 1'b1;
        end
      end
    end
    w_grant = v_taken;
  end

  // Register granted results onto the ROB ports and advance the pointer past
  // the last requester served; a flush cancels everything and restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_res_valid <= '0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
    end else if (flush_en) begin
      r_rr_ptr    <= '0;
      r_res_valid <= '0;
    end else begin
      r_res_valid <= w_port_vld;
      if (w_any) r_rr_ptr <= f_rot(w_last, 1);
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_port_vld[p]) begin
          r_res_idx[p*IDX_WIDTH +: IDX_WIDTH]    <= w_req_idx[w_port_sel[p]];
          r_res_data[p*DATA_WIDTH +: DATA_WIDTH] <= w_req_data[w_port_sel[p]];
        end
      end
    end
  end

  assign req_ready   = w_grant;
  assign res_valid   = r_res_valid;
  assign res_rob_idx = r_res_idx;
  assign res_data    = r_res_data;
  assign rr_ptr_o    = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_result_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_bus_arbiter
//  Purpose  : Self-checking bench for result_bus_arbiter (directed steps and
//             randomized FU traffic against a queue-based reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_bus_arbiter;

  localparam int N  = 4;
  localparam int P  = 2;
  localparam int IW = 5;
  localparam int DW = 32;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              flush_en;
  logic [N-1:0]      req_valid;
  logic [N*IW-1:0]   req_rob_idx;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [P-1:0]      res_valid;
  logic [P*IW-1:0]   res_rob_idx;
  logic [P*DW-1:0]   res_data;
  logic [PW-1:0]     rr_ptr_o;

  // Single-port instance for the starvation check
  logic [N-1:0]      s_valid;
  logic [N*IW-1:0]   s_idx;
  logic [N*DW-1:0]   s_data;
  logic [N-1:0]      s_ready;
  logic              s_res_valid;
  logic [IW-1:0]     s_res_idx;
  logic [DW-1:0]     s_res_data;
  logic [PW-1:0]     s_ptr;

  result_bus_arbiter #(.NUM_REQ(N), .NUM_PORTS(P), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush_en(flush_en),
    .req_valid(req_valid), .req_rob_idx(req_rob_idx), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_rob_idx(res_rob_idx),
    .res_data(res_data), .rr_ptr_o(rr_ptr_o)
  );

  result_bus_arbiter #(.NUM_REQ(N), .NUM_PORTS(1), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst(rst), .flush_en(1'b0),
    .req_valid(s_valid), .req_rob_idx(s_idx), .req_data(s_data),
    .req_ready(s_ready), .res_valid(s_res_valid), .res_rob_idx(s_res_idx),
    .res_data(s_res_data), .rr_ptr_o(s_ptr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              m_ptr;
  logic [P-1:0]    m_valid;
  logic [IW-1:0]   m_idx  [P];
  logic [DW-1:0]   m_data [P];
  logic [N-1:0]    exp_ready;
  int              exp_sel[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [IW-1:0] idx, input logic [DW-1:0] dat);
    req_rob_idx[k*IW +: IW] = idx;
    req_data[k*DW +: DW]    = dat;
  endtask

  // Walk the requesters in circular order from the pointer, first P valid win.
  task automatic model_arb();
    exp_sel.delete();
    exp_ready = '0;
    if (!rst && !flush_en) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (req_valid[k] && exp_sel.size() < P) begin
          exp_sel.push_back(k);
          exp_ready[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ptr = 0;
      m_valid = '0;
      for (int p = 0; p < P; p++) begin m_idx[p] = '0; m_data[p] = '0; end
    end else if (flush_en) begin
      m_ptr = 0;
      m_valid = '0;
    end else begin
      m_valid = '0;
      foreach (exp_sel[p]) begin
        m_valid[p] = 1'b1;
        m_idx[p]   = req_rob_idx[exp_sel[p]*IW +: IW];
        m_data[p]  = req_data[exp_sel[p]*DW +: DW];
      end
      if (exp_sel.size() > 0) m_ptr = (exp_sel[exp_sel.size()-1] + 1) % N;
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".ptr"}, 64'(rr_ptr_o), 64'(m_ptr));
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(m_valid));
    for (int p = 0; p < P; p++) begin
      if (m_valid[p]) begin
        chk({tag, ".res_idx"}, 64'(res_rob_idx[p*IW +: IW]), 64'(m_idx[p]));
        chk({tag, ".res_data"}, 64'(res_data[p*DW +: DW]), 64'(m_data[p]));
      end
    end
  endtask

  // Inputs are already applied at the falling edge; check ready, clock once,
  // then check the registered outputs at the next falling edge.
  task automatic cycle(input string tag);
    #1;
    model_arb();
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    int waits [N];
    int max_wait;
    rst = 1'b1; flush_en = 1'b0;
    req_valid = '0; req_rob_idx = '0; req_data = '0;
    s_valid = '0; s_idx = '0; s_data = '0;
    model_edge();
    @(negedge clk); @(negedge clk);
    check_out("reset");
    chk("reset.ready", 64'(req_ready), 64'(0));
    rst = 1'b0;

    // Single requester
    set_req(2, 5'd7, 32'hDEAD);
    req_valid = 4'b0100;
    cycle("single");
    chk("single.ready_c", 64'(exp_ready), 64'(4'b0100));
    chk("single.valid_c", 64'(res_valid), 64'(2'b01));
    chk("single.idx_c", 64'(res_rob_idx[IW-1:0]), 64'(7));
    chk("single.data_c", 64'(res_data[DW-1:0]), 64'(32'hDEAD));
    chk("single.ptr_c", 64'(rr_ptr_o), 64'(3));
    req_valid = '0;

    // Wrap-around from pointer 3
    set_req(3, 5'd19, 32'h3333_0003);
    set_req(0, 5'd4,  32'h0000_AAAA);
    req_valid = 4'b1001;
    cycle("wrap");
    chk("wrap.idx0_c", 64'(res_rob_idx[IW-1:0]), 64'(19));
    chk("wrap.idx1_c", 64'(res_rob_idx[2*IW-1:IW]), 64'(4));
    chk("wrap.ptr_c", 64'(rr_ptr_o), 64'(1));

    // Flush with a grant pending
    set_req(0, 5'd10, 32'h1000_0000);
    set_req(1, 5'd11, 32'h1100_0000);
    req_valid = 4'b0011;
    flush_en = 1'b1;
    cycle("flush");
    chk("flush.valid_c", 64'(res_valid), 64'(0));
    chk("flush.ptr_c", 64'(rr_ptr_o), 64'(0));
    flush_en = 1'b0;

    // Contention with rotation; FU0/FU1 re-present after the flush
    set_req(2, 5'd12, 32'h1200_0000);
    set_req(3, 5'd13, 32'h1300_0000);
    req_valid = 4'b1111;
    cycle("cont1");
    chk("cont1.ptr_c", 64'(rr_ptr_o), 64'(2));
    req_valid = 4'b1100;
    cycle("cont2");
    chk("cont2.ptr_c", 64'(rr_ptr_o), 64'(0));
    req_valid = '0;

    // Randomized FU traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) != 0) begin
          set_req(k, IW'($urandom_range(0, 31)), $urandom);
          req_valid[k] = 1'b1;
        end
      end
      flush_en = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      cycle("rand");
      for (int k = 0; k < N; k++) if (exp_ready[k]) req_valid[k] = 1'b0;
    end
    rst = 1'b0; flush_en = 1'b0;

    // Reset asserted in the middle of traffic acts immediately
    req_valid = 4'b1111;
    cycle("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("rst.res_valid", 64'(res_valid), 64'(0));
    chk("rst.ready", 64'(req_ready), 64'(0));
    model_edge();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.ptr_after", 64'(rr_ptr_o), 64'(0));
    req_valid = '0;
    @(negedge clk);

    // Starvation check on the single-port instance
    for (int k = 0; k < N; k++) waits[k] = 0;
    max_wait = 0;
    s_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("starve.order", 64'(s_ready), 64'(1 << (c % N)));
      for (int k = 0; k < N; k++) begin
        if (s_ready[k]) waits[k] = 0;
        else waits[k]++;
        if (waits[k] > max_wait) max_wait = waits[k];
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("starve.max_wait", 64'(max_wait <= N - 1), 64'(1));
    s_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
